// File: rtl/avr_irq_pkg.sv
// Shared constants for the AVR interrupt controller:
// register offsets, CTRL bit positions and FSM state encoding.
package avr_irq_pkg;

  localparam logic [1:0] REG_IE   = 2'd0;
  localparam logic [1:0] REG_IP   = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int CTRL_GIE    = 7;
  localparam int CTRL_EOI    = 6;
  localparam int CTRL_ACTIVE = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage

// File: rtl/avr_irq_prio_enc.sv
// Lowest-index priority encoder.
// req_i: request vector; idx_o: lowest set index; valid_o: any set.
module avr_irq_prio_enc #(
  parameter int NSRC = 8,
  parameter int VECW = 3
) (
  input  logic [NSRC-1:0] req_i,
  output logic [VECW-1:0] idx_o,
  output logic            valid_o
);

  // Scan downward so the lowest set index is written last.
  always_comb begin
    idx_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = VECW'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/avr_irq_ctrl.sv
// Interrupt controller for the soft AVR core: edge-latched
// sources, IE mask, priority select, req/ack/EOI sequencing.
// Ports: clk/rst (sync, active-high); io_re/io_we/io_a/io_di/
// io_do I/O bus; irq_src peripheral lines; irq/irq_vec/irq_ack
// core interface.
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int VECW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            io_re,
  input  logic            io_we,
  input  logic [1:0]      io_a,
  input  logic [7:0]      io_di,
  output logic [7:0]      io_do,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq,
  output logic [VECW-1:0] irq_vec,
  input  logic            irq_ack
);

  logic [NSRC-1:0] ie_q, ie_d;
  logic [NSRC-1:0] ip_q, ip_d;
  logic [NSRC-1:0] src_q;
  logic            gie_q, gie_d;
  logic [1:0]      st_q, st_d;
  logic [VECW-1:0] vec_q, vec_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] sel;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic [VECW-1:0] win;
  logic            win_v;
  logic            wr_ie, wr_ip, wr_ctrl;
  logic            eoi;
  logic            ack_hit;
  logic            cur_ip, cur_ie;
  logic [7:0]      vec8;
  logic [7:0]      ctrl_rd;

  assign rise    = irq_src & ~src_q;
  assign elig    = ip_q & ie_q;
  assign wr_ie   = io_we && (io_a == REG_IE);
  assign wr_ip   = io_we && (io_a == REG_IP);
  assign wr_ctrl = io_we && (io_a == REG_CTRL);
  assign eoi     = wr_ctrl && io_di[CTRL_EOI];

  avr_irq_prio_enc #(
    .NSRC (NSRC),
    .VECW (VECW)
  ) u_enc (
    .req_i   (elig),
    .idx_o   (win),
    .valid_o (win_v)
  );

  // One-hot of the presented vector.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel[i] = (vec_q == VECW'(i));
    end
  end

  assign cur_ip  = |(ip_q & sel);
  assign cur_ie  = |(ie_q & sel);
  assign ack_hit = (st_q == ST_REQ) && irq_ack;
  assign w1c     = wr_ip ? io_di[NSRC-1:0] : '0;
  assign ack_clr = ack_hit ? sel : '0;

  // Edge set is OR-ed last so it beats both clears.
  assign ip_d  = (ip_q & ~(w1c | ack_clr)) | rise;
  assign ie_d  = wr_ie ? io_di[NSRC-1:0] : ie_q;
  assign gie_d = wr_ctrl ? io_di[CTRL_GIE] : gie_q;

  always_comb begin
    st_d  = st_q;
    vec_d = vec_q;
    unique case (st_q)
      ST_IDLE: begin
        if (gie_q && win_v) begin
          vec_d = win;
          st_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          st_d = ST_ACTIVE;
        end else if (!cur_ip || !cur_ie || !gie_q) begin
          st_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (eoi) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q  <= '0;
      ip_q  <= '0;
      src_q <= '0;
      gie_q <= 1'b0;
      st_q  <= ST_IDLE;
      vec_q <= '0;
    end else begin
      ie_q  <= ie_d;
      ip_q  <= ip_d;
      src_q <= irq_src;
      gie_q <= gie_d;
      st_q  <= st_d;
      vec_q <= vec_d;
    end
  end

  assign irq     = (st_q == ST_REQ);
  assign irq_vec = vec_q;

  assign vec8    = 8'(vec_q);
  assign ctrl_rd = {gie_q, 3'b000,
                    st_q == ST_ACTIVE, vec8[2:0]};

  always_comb begin
    io_do = 8'h00;
    if (io_re) begin
      case (io_a)
        REG_IE:   io_do = 8'(ie_q);
        REG_IP:   io_do = 8'(ip_q);
        REG_CTRL: io_do = ctrl_rd;
        default:  io_do = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Self-checking bench for avr_irq_ctrl: directed scenarios
// followed by randomized traffic against a reference model.
module tb_avr_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [1:0] io_a = 2'd0;
  logic [7:0] io_di = 8'h00;
  logic [7:0] io_do;
  logic [7:0] irq_src = 8'h00;
  logic       irq;
  logic [2:0] irq_vec;
  logic       irq_ack = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: pending/enable sets, a "requesting" flag,
  // an "in service" flag and the presented index.
  logic [7:0] m_ie = 0, m_ip = 0, m_prev = 0;
  logic       m_gie = 0, m_req = 0, m_act = 0;
  logic [2:0] m_vec = 0;

  avr_irq_ctrl #(.NSRC(8), .VECW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_re   (io_re),
    .io_we   (io_we),
    .io_a    (io_a),
    .io_di   (io_di),
    .io_do   (io_do),
    .irq_src (irq_src),
    .irq     (irq),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack)
  );

  always #10 clk = ~clk;

  function automatic logic [2:0] lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic chk(string tag, logic [7:0] got,
                     logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic rd(logic [1:0] a, output logic [7:0] d);
    logic [1:0] sa;
    sa = io_a;
    io_re = 1'b1;
    io_a = a;
    #1;
    d = io_do;
    io_re = 1'b0;
    io_a = sa;
    #1;
  endtask

  task automatic check_model();
    logic [7:0] d;
    chk("irq", {7'd0, irq}, {7'd0, m_req});
    chk("irq_vec", {5'd0, irq_vec}, {5'd0, m_vec});
    rd(2'd0, d); chk("rd_ie", d, m_ie);
    rd(2'd1, d); chk("rd_ip", d, m_ip);
    rd(2'd2, d);
    chk("rd_ctrl", d, {m_gie, 3'b000, m_act, m_vec});
    rd(2'd3, d); chk("rd_r3", d, 8'h00);
    chk("io_do_idle", io_do, 8'h00);
  endtask

  task automatic step();
    logic [7:0] rise, clr, elig, n_ip, n_ie;
    logic       n_gie, n_req, n_act, eoi;
    logic [2:0] n_vec;
    rise = irq_src & ~m_prev;
    if (rst) begin
      n_ip = 0; n_ie = 0; n_gie = 0;
      n_req = 0; n_act = 0; n_vec = 0;
    end else begin
      clr = (io_we && io_a == 2'd1) ? io_di : 8'h00;
      if (m_req && irq_ack) clr = clr | (8'h01 << m_vec);
      n_ip = (m_ip & ~clr) | rise;
      n_ie = (io_we && io_a == 2'd0) ? io_di : m_ie;
      n_gie = (io_we && io_a == 2'd2) ? io_di[7] : m_gie;
      eoi = io_we && io_a == 2'd2 && io_di[6];
      elig = m_ip & m_ie;
      n_req = m_req; n_act = m_act; n_vec = m_vec;
      if (!m_req && !m_act) begin
        if (m_gie && elig != 0) begin
          n_vec = lowest(elig);
          n_req = 1;
        end
      end else if (m_req) begin
        if (irq_ack) begin
          n_req = 0; n_act = 1;
        end else if (!m_ip[m_vec] || !m_ie[m_vec] || !m_gie) begin
          n_req = 0;
        end
      end else if (eoi) begin
        n_act = 0;
      end
    end
    @(posedge clk);
    m_prev = rst ? 8'h00 : irq_src;
    m_ip = n_ip; m_ie = n_ie; m_gie = n_gie;
    m_req = n_req; m_act = n_act; m_vec = n_vec;
    #1;
    check_model();
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    io_we = 1'b1; io_a = a; io_di = d;
    step();
    io_we = 1'b0; io_di = 8'h00;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_irq", {7'd0, irq}, 8'h00);

    // Single source, 2-cycle latency, ack -> ACTIVE.
    wr(2'd0, 8'h05);
    wr(2'd2, 8'h80);
    irq_src = 8'h04;
    step();
    irq_src = 8'h00;
    rd(2'd1, d); chk("t1_ip", d, 8'h04);
    chk("t1_irq_lat1", {7'd0, irq}, 8'h00);
    step();
    chk("t1_irq", {7'd0, irq}, 8'h01);
    chk("t1_vec", {5'd0, irq_vec}, 8'h02);
    ack();
    rd(2'd1, d); chk("t1_ip_clr", d, 8'h00);
    rd(2'd2, d); chk("t1_ctrl", d, 8'h8A);
    chk("t1_irq_low", {7'd0, irq}, 8'h00);
    wr(2'd2, 8'hC0);

    // Two simultaneous edges: lowest index first.
    wr(2'd0, 8'hFF);
    irq_src = 8'h22;
    step();
    irq_src = 8'h00;
    step();
    chk("t2_vec1", {5'd0, irq_vec}, 8'h01);
    ack();
    wr(2'd2, 8'hC0);
    step();
    chk("t2_irq5", {7'd0, irq}, 8'h01);
    chk("t2_vec5", {5'd0, irq_vec}, 8'h05);
    ack();
    wr(2'd2, 8'hC0);

    // Withdrawal by W1C while requesting.
    irq_src = 8'h08;
    step();
    irq_src = 8'h00;
    step();
    chk("t3_req", {7'd0, irq}, 8'h01);
    wr(2'd1, 8'h08);
    step();
    chk("t3_drop", {7'd0, irq}, 8'h00);
    ack();
    rd(2'd2, d); chk("t3_ctrl", d, 8'h83);
    rd(2'd1, d); chk("t3_ip", d, 8'h00);

    // Edge during ACTIVE waits for EOI.
    irq_src = 8'h80;
    step();
    irq_src = 8'h00;
    step();
    ack();
    irq_src = 8'h01;
    step();
    irq_src = 8'h00;
    repeat (3) step();
    chk("t4_hold", {7'd0, irq}, 8'h00);
    rd(2'd1, d); chk("t4_ip", d, 8'h01);
    wr(2'd2, 8'hC0);
    step();
    chk("t4_irq", {7'd0, irq}, 8'h01);
    chk("t4_vec", {5'd0, irq_vec}, 8'h00);
    ack();
    wr(2'd2, 8'hC0);

    // Edge beats W1C; held level gives one set only.
    irq_src = 8'h10;
    wr(2'd1, 8'h10);
    rd(2'd1, d); chk("t5_ip", d, 8'h10);
    step();
    ack();
    repeat (10) step();
    rd(2'd1, d); chk("t5_noreset", d, 8'h00);
    irq_src = 8'h00;
    wr(2'd2, 8'hC0);

    // Reset while requesting.
    irq_src = 8'h40;
    step();
    irq_src = 8'h00;
    step();
    chk("t6_req", {7'd0, irq}, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_irq", {7'd0, irq}, 8'h00);
    rd(2'd0, d); chk("t6_ie", d, 8'h00);
    rd(2'd2, d); chk("t6_ctrl", d, 8'h00);
    chk("t6_io_do", io_do, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      irq_src = 8'($urandom & $urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      io_we = ($urandom_range(0, 3) == 0);
      io_a = 2'($urandom_range(0, 3));
      io_di = 8'($urandom);
      if (io_a == 2'd2 && $urandom_range(0, 1) == 1)
        io_di[7] = 1'b1;
      step();
    end
    rst = 1'b0; io_we = 1'b0; irq_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
